// File: rtl/data_sram_responder.sv
// data_sram_responder: CPU data SRAM responder; word RAM plus config window (timer, scratch, LED, miss count).
// Latency: read data registered, valid the cycle after the access; writes commit at that same edge.
// Backpressure: none, one access accepted every cycle. Timer flop built only with DSRESP_TIMER_EN defined.
module data_sram_responder #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic [7:0]  conf_miss
);
    // Config offsets compared on word granularity (addr[15:2]).
    localparam logic [13:0] OFF_TIMER   = 14'h0000;
    localparam logic [13:0] OFF_SCRATCH = 14'h0001;
    localparam logic [13:0] OFF_LED     = 14'h0002;
    localparam logic [13:0] OFF_MISS    = 14'h0003;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0] ram_idx;
    logic [13:0]       conf_off;
    logic              conf_sel;
    logic              acc_wr;
    logic              acc_rd;
    logic              ram_wr;
    logic [31:0]       wmask;
    logic [31:0]       timer_rd;
    logic [31:0]       conf_rdata;
    logic              miss_hit;
    logic              unused_addr_lo;

    logic [31:0]       rdata_q,   rdata_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [15:0]       led_q,     led_d;
    logic [7:0]        miss_q,    miss_d;

    assign ram_idx        = data_sram_addr[ADDR_W+1:2];
    assign conf_off       = data_sram_addr[15:2];
    assign conf_sel       = (data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign acc_wr         = data_sram_en && (data_sram_we != 4'h0);
    assign acc_rd         = data_sram_en && (data_sram_we == 4'h0);
    assign unused_addr_lo = ^data_sram_addr[1:0];
    assign wmask          = {{8{data_sram_we[3]}}, {8{data_sram_we[2]}},
                             {8{data_sram_we[1]}}, {8{data_sram_we[0]}}};

    // A write racing an asynchronous reset is abandoned, RAM included.
    assign ram_wr = acc_wr && !conf_sel && resetn;

`ifdef DSRESP_TIMER_EN
    logic [31:0] timer_q, timer_d;

    assign timer_rd = timer_q;

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (acc_wr && conf_sel && (conf_off == OFF_TIMER)) begin
            timer_d = (timer_q & ~wmask) | (data_sram_wdata & wmask);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= 32'h0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timer_rd = 32'h0;
`endif

    always_comb begin
        scratch_d  = scratch_q;
        led_d      = led_q;
        miss_d     = miss_q;
        rdata_d    = rdata_q;
        conf_rdata = 32'h0;
        miss_hit   = 1'b0;

        case (conf_off)
            OFF_TIMER: begin
                conf_rdata = timer_rd;
            end
            OFF_SCRATCH: begin
                conf_rdata = scratch_q;
                if (acc_wr && conf_sel) begin
                    scratch_d = (scratch_q & ~wmask) | (data_sram_wdata & wmask);
                end
            end
            OFF_LED: begin
                conf_rdata = {16'h0, led_q};
                if (acc_wr && conf_sel) begin
                    led_d = (led_q & ~wmask[15:0]) | (data_sram_wdata[15:0] & wmask[15:0]);
                end
            end
            OFF_MISS: begin
                conf_rdata = {24'h0, miss_q};
            end
            default: begin
                miss_hit = data_sram_en && conf_sel;
            end
        endcase

        if (miss_hit && (miss_q != 8'hff)) begin
            miss_d = miss_q + 8'd1;
        end

        if (acc_rd) begin
            rdata_d = conf_sel ? conf_rdata : mem[ram_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= 32'h0;
            scratch_q <= 32'h0;
            led_q     <= 16'hffff;
            miss_q    <= 8'h0;
        end else begin
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            led_q     <= led_d;
            miss_q    <= miss_d;
        end
    end

    // RAM contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign conf_miss       = miss_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: fixed vector table, hand sequences, then random traffic vs a reference model.
module tb_data_sram_responder;
    localparam int unsigned ADDR_W = 12;
    localparam logic [31:0] CB     = 32'hbfaf_0000;
`ifdef DSRESP_TIMER_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        en     = 1'b0;
    logic [3:0]  we     = 4'h0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [7:0]  miss;

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_W(ADDR_W), .CONF_BASE(CB)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .conf_miss       (miss)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [31:0] m_timer, m_scratch, m_rdata;
    logic [15:0] m_led;
    logic [7:0]  m_miss;
    bit          m_rd_known;
    logic [31:0] m_ram [int];

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
        logic [7:0]  exp_miss;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_timer = 32'h0; m_scratch = 32'h0; m_rdata = 32'h0;
        m_led = 16'hffff; m_miss = 8'h0; m_rd_known = 1'b1;
    endtask

    task automatic do_reset();
        en = 1'b0; we = 4'h0; resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
    endtask

    // Drive one access, predict from the rules, clock it, compare.
    task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask, rv, t_next;
        int          key;
        bit          known;
        en = e; we = w; addr = a; wdata = d;
        mask   = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        t_next = m_timer + 32'd1;
        rv     = 32'h0;
        known  = 1'b1;
        key    = int'(a[ADDR_W+1:2]);
        if (e) begin
            if (a[31:16] == CB[31:16]) begin
                case (a[15:0] & 16'hfffc)
                    16'h0000: begin
                        rv = m_timer;
                        if (w != 4'h0) t_next = (m_timer & ~mask) | (d & mask);
                    end
                    16'h0004: begin
                        rv = m_scratch;
                        if (w != 4'h0) m_scratch = (m_scratch & ~mask) | (d & mask);
                    end
                    16'h0008: begin
                        rv = {16'h0, m_led};
                        if (w != 4'h0) m_led = (m_led & ~mask[15:0]) | (d[15:0] & mask[15:0]);
                    end
                    16'h000c: rv = {24'h0, m_miss};
                    default: if (m_miss != 8'hff) m_miss = m_miss + 8'd1;
                endcase
            end else if (w == 4'h0) begin
                if (m_ram.exists(key)) rv = m_ram[key];
                else known = 1'b0;
            end else if (m_ram.exists(key)) begin
                m_ram[key] = (m_ram[key] & ~mask) | (d & mask);
            end else if (w == 4'hf) begin
                m_ram[key] = d;
            end
        end
        if (e && w == 4'h0) begin
            m_rdata    = rv;
            m_rd_known = known;
        end
        m_timer = TEN ? t_next : 32'h0;
        @(posedge clk); #1;
        if (m_rd_known) chk("model_rdata", rdata, m_rdata);
        chk("model_led", {16'h0, led}, {16'h0, m_led});
        chk("model_miss", {24'h0, miss}, {24'h0, m_miss});
    endtask

    function automatic logic [31:0] ram_addr(input int k);
        logic [15:0] hi;
        logic [11:0] idx;
        hi = 16'($urandom);
        if (hi == CB[31:16]) hi = hi ^ 16'h1;
        idx = 12'(k * 263);
        return {hi, 2'($urandom), idx, 2'($urandom)};
    endfunction

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        int          r;

        tbl[0]  = '{1'b1, 4'hf, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 16'hffff, 8'h00};
        tbl[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 16'hffff, 8'h00};
        tbl[2]  = '{1'b1, 4'h4, 32'h0000_0010, 32'haabb_ccdd, 32'h1234_5678, 16'hffff, 8'h00};
        tbl[3]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h12bb_5678, 16'hffff, 8'h00};
        tbl[4]  = '{1'b1, 4'hf, CB + 32'h8,    32'h0000_a5a5, 32'h12bb_5678, 16'ha5a5, 8'h00};
        tbl[5]  = '{1'b1, 4'h0, CB + 32'h8,    32'h0000_0000, 32'h0000_a5a5, 16'ha5a5, 8'h00};
        tbl[6]  = '{1'b1, 4'hf, CB + 32'h4,    32'hdead_beef, 32'h0000_a5a5, 16'ha5a5, 8'h00};
        tbl[7]  = '{1'b1, 4'h0, CB + 32'h4,    32'h0000_0000, 32'hdead_beef, 16'ha5a5, 8'h00};
        tbl[8]  = '{1'b1, 4'h3, CB + 32'h8,    32'hffff_0180, 32'hdead_beef, 16'h0180, 8'h00};
        tbl[9]  = '{1'b1, 4'h0, CB + 32'h8,    32'h0000_0000, 32'h0000_0180, 16'h0180, 8'h00};
        tbl[10] = '{1'b1, 4'h1, 32'h0000_4010, 32'h0000_00ee, 32'h0000_0180, 16'h0180, 8'h00};
        tbl[11] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h12bb_56ee, 16'h0180, 8'h00};
        tbl[12] = '{1'b1, 4'h0, CB + 32'hc,    32'h0000_0000, 32'h0000_0000, 16'h0180, 8'h00};
        tbl[13] = '{1'b1, 4'hf, CB + 32'h10,   32'hffff_ffff, 32'h0000_0000, 16'h0180, 8'h01};
        tbl[14] = '{1'b1, 4'h0, CB + 32'he,    32'h0000_0000, 32'h0000_0001, 16'h0180, 8'h01};
        tbl[15] = '{1'b0, 4'hf, 32'h0000_0010, 32'h0000_0000, 32'h0000_0001, 16'h0180, 8'h01};
        tbl[16] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h12bb_56ee, 16'h0180, 8'h01};
        tbl[17] = '{1'b1, 4'h0, 32'hbfae_0010, 32'h0000_0000, 32'h12bb_56ee, 16'h0180, 8'h01};

        model_reset();
        do_reset();
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0000_ffff);
        chk("reset_miss", {24'h0, miss}, 32'h0);

        // Timer: read on the 5th cycle after reset release, then wrap.
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'h0, CB, 32'h0);
        chk("timer_5th", rdata, TEN ? 32'd4 : 32'd0);
        step(1'b1, 4'hf, CB, 32'hffff_ffff);
        step(1'b1, 4'h0, CB, 32'h0);
        chk("timer_written", rdata, TEN ? 32'hffff_ffff : 32'h0);
        step(1'b1, 4'h0, CB, 32'h0);
        chk("timer_wrap", rdata, 32'h0);
        chk("timer_wr_no_miss", {24'h0, miss}, 32'h0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
            chk($sformatf("tbl%0d_miss", i), {24'h0, miss}, {24'h0, tbl[i].exp_miss});
        end

        // Back-to-back read / write / read of one word.
        step(1'b1, 4'hf, 32'h0000_0040, 32'h1111_1111);
        step(1'b1, 4'h0, 32'h0000_0040, 32'h0);
        chk("b2b_old", rdata, 32'h1111_1111);
        step(1'b1, 4'hf, 32'h0000_0040, 32'h2222_2222);
        chk("b2b_hold", rdata, 32'h1111_1111);
        step(1'b1, 4'h0, 32'h0000_0040, 32'h0);
        chk("b2b_new", rdata, 32'h2222_2222);

        // Reset asserted in the middle of an LED write.
        step(1'b1, 4'hf, CB + 32'h4, 32'hcafe_f00d);
        step(1'b1, 4'h0, CB + 32'h4, 32'h0);
        chk("scratch_rd", rdata, 32'hcafe_f00d);
        en = 1'b1; we = 4'hf; addr = CB + 32'h8; wdata = 32'h0000_1234;
        resetn = 1'b0;
        #1;
        chk("midrst_led_now", {16'h0, led}, 32'h0000_ffff);
        chk("midrst_rdata_now", rdata, 32'h0);
        @(posedge clk); #1;
        chk("midrst_led_edge", {16'h0, led}, 32'h0000_ffff);
        en = 1'b0; we = 4'h0;
        resetn = 1'b1;
        model_reset();
        step(1'b1, 4'h0, CB + 32'h4, 32'h0);
        chk("scratch_after_rst", rdata, 32'h0);

        // Miss counter saturation.
        step(1'b1, 4'hf, CB + 32'hc, 32'h5555_5555);
        chk("miss_wr_ro", {24'h0, miss}, 32'h0);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 4'h0, CB + 32'h20, 32'h0);
            chk("miss_rd_zero", rdata, 32'h0);
        end
        chk("miss_sat", {24'h0, miss}, 32'h0000_00ff);
        step(1'b1, 4'h0, CB + 32'hc, 32'h0);
        chk("miss_reg_rd", rdata, 32'h0000_00ff);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 16; k++) step(1'b1, 4'hf, ram_addr(k), $urandom);
        for (int i = 0; i < 3000; i++) begin
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                a = ram_addr(int'($urandom_range(0, 15)));
            end else if (r < 9) begin
                a = CB | {16'h0, 12'h0, 2'(r - 5), 2'($urandom)};
            end else begin
                a = CB | {16'h0, 16'($urandom_range(0, 255))};
            end
            step($urandom_range(0, 9) != 0, w, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
